registry_mb: RTL

REGISTRY_MB -- requirements
Module: registry_mb

---
 rtl/registry_pkg.sv | 30 +++
 rtl/hs_rx.sv | 51 +++++
 rtl/registry_mb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/registry_pkg.sv
// rtl/registry_pkg.sv - shared FSM state type and sizing helpers for the register mailbox
// Purpose: state enum plus the opcode-bit and byte-count helper functions used by registry_mb.
// Ports: none (package).
package registry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_COMMIT,
    ST_RD_LOAD,
    ST_RD_SEND,
    ST_RD_WAIT
  } state_t;

  // Number of stream bytes needed to carry one register value.
  function automatic int bytes_for(input int reg_width, input int byte_width);
    return (reg_width + byte_width - 1) / byte_width;
  endfunction

  // The opcode lives in the top bit of a command byte (0 = write, 1 = read).
  function automatic int op_bit(input int byte_width);
    return byte_width - 1;
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hs_rx.sv
// rtl/hs_rx.sv - 4-phase inbound byte acceptor
// Purpose: accepts one byte per valid/ack 4-phase cycle and emits a one-cycle strobe with the
//          captured byte; i_en gates new acceptances so the consumer can stall the sender.
// Ports:
//   i_clk, i_rstb       clock, asynchronous active-low reset
//   i_en                consumer ready to take a new byte
//   i_data, i_valid     inbound byte and its valid
//   o_ack               4-phase acknowledge back to the sender
//   o_data, o_strobe    captured byte, pulsed for one cycle per accepted byte
module hs_rx #(
  parameter int C_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rstb,
  input  logic               i_en,
  input  logic [C_WIDTH-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ack,
  output logic [C_WIDTH-1:0] o_data,
  output logic               o_strobe
);

  logic               r_ack;
  logic [C_WIDTH-1:0] r_data;
  logic               r_strobe;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_ack    <= 1'b0;
      r_data   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (!r_ack) begin
        // A byte is taken only while ack is low, so a held valid cannot be accepted twice.
        if (i_valid && i_en) begin
          r_ack    <= 1'b1;
          r_data   <= i_data;
          r_strobe <= 1'b1;
        end
      end else if (!i_valid) begin
        r_ack <= 1'b0;
      end
    end
  end

  assign o_ack    = r_ack;
  assign o_data   = r_data;
  assign o_strobe = r_strobe;

endmodule

// File: rtl/registry_mb.sv
// rtl/registry_mb.sv - byte-stream register mailbox with write commit and readback
// Purpose: decodes command bytes from a 4-phase byte stream; writes collect a little-endian
//          payload into a shadow and commit it atomically, reads stream a register back.
// Ports:
//   rstb, clk            asynchronous active-low reset, clock
//   data, valid, ack     inbound command/payload byte stream (4-phase)
//   tx_data, tx_valid,   readback byte stream; tx_valid held until tx_ack
//   tx_ack
//   register             packed register contents, register i at [i*W +: W]
//   update               one-cycle commit strobe per register
//   error                one-cycle pulse on write payload timeout
module registry_mb
  import registry_pkg::*;
#(
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_REG_COUNT       = 16,
  parameter int C_REG_WIDTH       = 16,
  parameter int C_TIMEOUT         = 100000
) (
  input  logic                               rstb,
  input  logic                               clk,
  input  logic [C_UART_DATA_WIDTH-1:0]       data,
  input  logic                               valid,
  output logic                               ack,
  output logic [C_UART_DATA_WIDTH-1:0]       tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ack,
  output logic [C_REG_COUNT*C_REG_WIDTH-1:0] register,
  output logic [C_REG_COUNT-1:0]             update,
  output logic                               error
);

  localparam int C_ADDR_WIDTH = $clog2(C_REG_COUNT);
  localparam int C_BYTES      = bytes_for(C_REG_WIDTH, C_UART_DATA_WIDTH);
  localparam int C_SH_WIDTH   = C_BYTES * C_UART_DATA_WIDTH;
  localparam int C_BCNT_WIDTH = cnt_width(C_BYTES);
  localparam int C_TCNT_WIDTH = cnt_width(C_TIMEOUT);
  localparam int C_OP_BIT     = op_bit(C_UART_DATA_WIDTH);

  state_t                             r_state;
  logic [C_ADDR_WIDTH-1:0]            r_addr;
  logic [C_BCNT_WIDTH-1:0]            r_byte;
  logic [C_TCNT_WIDTH-1:0]            r_tmo;
  logic [C_REG_WIDTH-1:0]             r_shadow;
  logic [C_SH_WIDTH-1:0]              r_rd;
  logic [C_REG_COUNT*C_REG_WIDTH-1:0] r_regs;
  logic [C_REG_COUNT-1:0]             r_update;
  logic                               r_error;
  logic [C_UART_DATA_WIDTH-1:0]       r_tx_data;
  logic                               r_tx_valid;

  logic [C_UART_DATA_WIDTH-1:0]       w_rx_data;
  logic                               w_rx_strobe;
  logic                               w_rx_en;
  logic [C_SH_WIDTH-1:0]              w_sel;

  // Bytes are only taken while a command or payload can be consumed; a pending strobe
  // also blocks so the FSM never sees two bytes in one cycle.
  assign w_rx_en = ((r_state == ST_IDLE) || (r_state == ST_WR_DATA)) && !w_rx_strobe;

  hs_rx #(
    .C_WIDTH (C_UART_DATA_WIDTH)
  ) u_hs_rx (
    .i_clk    (clk),
    .i_rstb   (rstb),
    .i_en     (w_rx_en),
    .i_data   (data),
    .i_valid  (valid),
    .o_ack    (ack),
    .o_data   (w_rx_data),
    .o_strobe (w_rx_strobe)
  );

  // Addressed register, zero-extended to whole bytes; no match (out of range) reads as zero.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < C_REG_COUNT; i++) begin
      if (r_addr == C_ADDR_WIDTH'(i)) begin
        w_sel[C_REG_WIDTH-1:0] = r_regs[i*C_REG_WIDTH +: C_REG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_byte     <= '0;
      r_tmo      <= '0;
      r_shadow   <= '0;
      r_rd       <= '0;
      r_regs     <= '0;
      r_update   <= '0;
      r_error    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_update <= '0;
      r_error  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tmo <= '0;
          if (w_rx_strobe) begin
            r_addr  <= w_rx_data[C_ADDR_WIDTH-1:0];
            r_byte  <= '0;
            r_state <= w_rx_data[C_OP_BIT] ? ST_RD_LOAD : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (w_rx_strobe) begin
            r_tmo <= '0;
            // Bits beyond the register width in the last byte are dropped here.
            for (int b = 0; b < C_REG_WIDTH; b++) begin
              if (int'(r_byte) == b / C_UART_DATA_WIDTH) begin
                r_shadow[b] <= w_rx_data[b % C_UART_DATA_WIDTH];
              end
            end
            if (r_byte == C_BCNT_WIDTH'(C_BYTES - 1)) begin
              r_state <= ST_COMMIT;
            end else begin
              r_byte <= r_byte + 1'b1;
            end
          end else if (r_tmo == C_TCNT_WIDTH'(C_TIMEOUT)) begin
            r_tmo    <= '0;
            r_shadow <= '0;
            r_error  <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < C_REG_COUNT; i++) begin
            if (r_addr == C_ADDR_WIDTH'(i)) begin
              r_regs[i*C_REG_WIDTH +: C_REG_WIDTH] <= r_shadow;
              r_update[i]                           <= 1'b1;
            end
          end
          r_state <= ST_IDLE;
        end
        ST_RD_LOAD: begin
          // Snapshot is kept as a shift register so each send takes the low byte.
          r_tx_data  <= w_sel[C_UART_DATA_WIDTH-1:0];
          r_rd       <= w_sel >> C_UART_DATA_WIDTH;
          r_tx_valid <= 1'b1;
          r_byte     <= '0;
          r_state    <= ST_RD_SEND;
        end
        ST_RD_SEND: begin
          if (tx_ack) begin
            r_tx_valid <= 1'b0;
            r_byte     <= r_byte + 1'b1;
            r_state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (!tx_ack) begin
            if (r_byte == C_BCNT_WIDTH'(C_BYTES)) begin
              r_tx_data <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_tx_data  <= r_rd[C_UART_DATA_WIDTH-1:0];
              r_rd       <= r_rd >> C_UART_DATA_WIDTH;
              r_tx_valid <= 1'b1;
              r_state    <= ST_RD_SEND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign register = r_regs;
  assign update   = r_update;
  assign error    = r_error;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule
